// File: rtl/i2s_tx_serializer.sv
// ----------------------------------------------------------------------------
// i2s_tx_serializer
//   I2S master transmitter for the DAC side of the audio path. Derives bclk and
//   lrclk from clk, accepts stereo frames through a valid/ready handshake into
//   a one-frame buffer and shifts each frame out MSB-first in Philips I2S
//   format (data starts one bclk after the lrclk edge). lrclk doubles as the
//   l_r_clk used by the EQ chain.
//
// Ports:
//   clk           system clock
//   reset         synchronous, active-low reset
//   sample_l      left sample, two's complement (passed through verbatim)
//   sample_r      right sample, two's complement (passed through verbatim)
//   sample_valid  sample_l/sample_r pair is valid
//   sample_ready  frame buffer empty; transfer when valid && ready
//   bclk          I2S bit clock, period 2*BCLK_DIV clk
//   lrclk         I2S word select, 0 = left, 1 = right
//   sdata         I2S serial data, changes on bclk falling events
//   underrun      one-clk pulse when a frame starts with an empty buffer
// ----------------------------------------------------------------------------
module i2s_tx_serializer #(
   parameter int DATA_WIDTH = 16,
   parameter int SLOT_BITS  = 32,   // must be >= DATA_WIDTH+1
   parameter int BCLK_DIV   = 4     // must be >= 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [DATA_WIDTH-1:0] sample_l,
   input  logic [DATA_WIDTH-1:0] sample_r,
   input  logic                  sample_valid,
   output logic                  sample_ready,
   output logic                  bclk,
   output logic                  lrclk,
   output logic                  sdata,
   output logic                  underrun
);

   localparam int DIV_W = $clog2(BCLK_DIV);
   localparam int POS_W = $clog2(SLOT_BITS);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);
   localparam logic [POS_W-1:0] POS_LAST = POS_W'(SLOT_BITS - 1);

   logic [DIV_W-1:0]      div_cnt;
   logic [POS_W-1:0]      pos;        // bit position within the current slot
   logic [DATA_WIDTH-1:0] buf_l, buf_r;
   logic [DATA_WIDTH-1:0] act_l, act_r;

   logic                  tick, fall, pos_wrap, frame_start, xfer;
   logic                  lr_nxt, sd_nxt;
   logic [POS_W-1:0]      pos_nxt;
   logic [DATA_WIDTH-1:0] word;

   // Everything that happens on a bclk falling event is computed here from
   // the values the slot counter and lrclk take on that same edge.
   always_comb begin
      // NOTE: every output of this block gets a default before any condition,
      // so no path leaves a signal unassigned and no latch is inferred.
      tick        = (div_cnt == DIV_LAST);
      fall        = tick && bclk;
      pos_wrap    = (pos == POS_LAST);
      pos_nxt     = pos_wrap ? '0 : pos + 1'b1;
      lr_nxt      = pos_wrap ? ~lrclk : lrclk;
      // lrclk 1->0 marks the start of a new left/right frame.
      frame_start = fall && pos_wrap && lrclk;
      xfer        = sample_valid && sample_ready;
      word        = lr_nxt ? act_r : act_l;
      sd_nxt      = 1'b0;
      // Position 0 is the I2S one-bit delay and positions past DATA_WIDTH are
      // padding, both zero; positions 1..DATA_WIDTH walk the word MSB-first.
      for (int i = 1; i <= DATA_WIDTH; i++) begin
         if (int'(pos_nxt) == i) sd_nxt = word[DATA_WIDTH-i];
      end
   end

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register sees the pre-edge value of every other register.
   always_ff @(posedge clk) begin
      if (!reset) begin
         div_cnt      <= '0;
         bclk         <= 1'b0;
         lrclk        <= 1'b1;
         pos          <= POS_LAST;
         sdata        <= 1'b0;
         sample_ready <= 1'b1;
         underrun     <= 1'b0;
         act_l        <= '0;
         act_r        <= '0;
      end else begin
         underrun <= 1'b0;

         if (tick) begin
            div_cnt <= '0;
            bclk    <= ~bclk;
         end else begin
            div_cnt <= div_cnt + 1'b1;
         end

         if (fall) begin
            pos   <= pos_nxt;
            lrclk <= lr_nxt;
            sdata <= sd_nxt;
         end

         if (xfer) sample_ready <= 1'b0;

         // Both channels are loaded together only here, so a frame never
         // mixes samples from two different transfers. A transfer landing on
         // an empty-buffer frame start stays buffered for the next frame.
         if (frame_start) begin
            if (!sample_ready) begin
               act_l        <= buf_l;
               act_r        <= buf_r;
               sample_ready <= 1'b1;
            end else begin
               act_l    <= '0;
               act_r    <= '0;
               underrun <= 1'b1;
            end
         end
      end
   end

   // NOTE: the buffer payload has no reset; the sample_ready flag alone says
   // whether it holds a frame, and it is only read while the flag is clear.
   always_ff @(posedge clk) begin
      if (xfer) begin
         buf_l <= sample_l;
         buf_r <= sample_r;
      end
   end

endmodule

// File: tb/tb_i2s_tx_serializer.sv
// ----------------------------------------------------------------------------
// tb_i2s_tx_serializer
//   Self-checking bench for i2s_tx_serializer (DATA_WIDTH=16, SLOT_BITS=32,
//   BCLK_DIV=2). Transfers push the expected frame onto a scoreboard queue;
//   a monitor pops it at each lrclk 1->0, rebuilds the expected 64-bit serial
//   stream, captures sdata on every bclk rise and compares.
// ----------------------------------------------------------------------------
module tb_i2s_tx_serializer;

   localparam int DW  = 16;
   localparam int TMO = 2000;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic [DW-1:0] sample_l = '0;
   logic [DW-1:0] sample_r = '0;
   logic          sample_valid = 1'b0;
   logic          sample_ready, bclk, lrclk, sdata, underrun;

   i2s_tx_serializer #(.DATA_WIDTH(DW), .SLOT_BITS(32), .BCLK_DIV(2)) dut (
      .clk          (clk),
      .reset        (reset),
      .sample_l     (sample_l),
      .sample_r     (sample_r),
      .sample_valid (sample_valid),
      .sample_ready (sample_ready),
      .bclk         (bclk),
      .lrclk        (lrclk),
      .sdata        (sdata),
      .underrun     (underrun)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [DW-1:0] l, r;     // stimulus
      logic [DW-1:0] el, er;   // expected slot contents, MSB first
   } vec_t;

   typedef struct {
      logic [DW-1:0] l, r;
      int            cyc;      // clk edge on which the transfer happens
   } exp_t;

   exp_t q[$];
   vec_t vecs[4];

   int checks = 0;
   int errors = 0;

   int cyc = 0;
   always @(posedge clk) cyc++;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic timeout(input string name);
      checks++;
      errors++;
      $display("FAIL %s: timed out (cycle %0d)", name, cyc);
   endtask

   // ---------------------------------------------------------------- monitor
   bit          mon_en = 1'b0;
   bit          capturing = 1'b0;
   logic        lr_prev = 1'b1, bclk_prev = 1'b0;
   int          n_starts = 0, n_done = 0, n_under = 0, ready_low = 0;
   int          fall_idx = 0, bit_idx = 0, last_start_cyc = 0;
   logic [63:0] cap_bits, exp_bits;
   logic        exp_under;
   exp_t        e;
   logic [DW-1:0] w;
   int          p_m;

   always @(negedge clk) begin
      if (mon_en) begin
         if (underrun)      n_under++;
         if (!sample_ready) ready_low++;
         if (lr_prev && !lrclk) begin
            n_starts++;
            last_start_cyc = cyc;
            fall_idx = 0;
            // A pair transferred on the frame-start edge itself is not used.
            if (q.size() > 0 && q[0].cyc < cyc) begin
               e = q.pop_front();
               exp_under = 1'b0;
            end else begin
               e.l = '0;
               e.r = '0;
               exp_under = 1'b1;
            end
            check("frame_underrun", 64'(underrun), 64'(exp_under));
            for (int k = 0; k < 64; k++) begin
               w   = (k < 32) ? e.l : e.r;
               p_m = k % 32;
               exp_bits[63-k] = (p_m >= 1 && p_m <= DW) ? w[DW-p_m] : 1'b0;
            end
            cap_bits  = '0;
            bit_idx   = 0;
            capturing = 1'b1;
         end else if (bclk_prev && !bclk) begin
            fall_idx++;
         end
         if (!bclk_prev && bclk && capturing) begin
            cap_bits[63-bit_idx] = sdata;
            bit_idx++;
            if (bit_idx == 64) begin
               check("frame_data", cap_bits, exp_bits);
               capturing = 1'b0;
               n_done++;
            end
         end
      end
      lr_prev   = lrclk;
      bclk_prev = bclk;
   end

   // ---------------------------------------------------------------- driver
   // Called at negedge+1. Waits for ready, lets the transfer happen on the
   // next edge and records the expected frame.
   task automatic send(input logic [DW-1:0] l, input logic [DW-1:0] r,
                       input logic [DW-1:0] el, input logic [DW-1:0] er,
                       input bit hold);
      exp_t x;
      int   t = 0;
      sample_l     = l;
      sample_r     = r;
      sample_valid = 1'b1;
      while (!sample_ready && t < TMO) begin
         @(negedge clk); #1;
         t++;
      end
      if (!sample_ready) begin
         timeout("send_wait_ready");
      end else begin
         if (t > 0) check("ready_return_cycle", 64'(cyc), 64'(last_start_cyc));
         x.l = el;
         x.r = er;
         x.cyc = cyc + 1;
         q.push_back(x);
         @(negedge clk); #1;
         check("ready_drop_after_xfer", 64'(sample_ready), 64'(0));
      end
      if (!hold) sample_valid = 1'b0;
   endtask

   task automatic wait_q_empty(input string name);
      int t = 0;
      while (q.size() != 0 && t < TMO) begin
         @(negedge clk); #1;
         t++;
      end
      if (q.size() != 0) timeout(name);
   endtask

   task automatic wait_done(input int target, input string name);
      int t = 0;
      while (n_done < target && t < TMO) begin
         @(negedge clk); #1;
         t++;
      end
      if (n_done < target) timeout(name);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   // ---------------------------------------------------------------- tests
   initial begin
      int s0, u0, r0, d0, t;

      vecs[0] = '{16'hA5C3, 16'h1234, 16'b1010010111000011, 16'b0001001000110100};
      vecs[1] = '{16'h8000, 16'hFFFF, 16'b1000000000000000, 16'b1111111111111111};
      vecs[2] = '{16'h0001, 16'h7FFE, 16'b0000000000000001, 16'b0111111111111110};
      vecs[3] = '{16'hFFFF, 16'h0000, 16'b1111111111111111, 16'b0000000000000000};

      // Reset held for 5 cycles with random inputs.
      @(negedge clk); #1;
      for (int i = 0; i < 5; i++) begin
         sample_l     = 16'($urandom);
         sample_r     = 16'($urandom);
         sample_valid = 1'($urandom_range(0, 1));
         @(negedge clk); #1;
         check("reset_outputs", 64'({bclk, lrclk, sdata, sample_ready, underrun}), 64'(5'b01010));
      end
      sample_valid = 1'b0;
      reset  = 1'b1;
      mon_en = 1'b1;

      // First frame timing runs alongside the table, whose first pair
      // transfers on the first edge after release.
      fork
         begin
            int k = 0;
            while (lrclk && k < 20) begin
               @(negedge clk); #1;
               k++;
            end
            check("first_frame_start_cycle", 64'(k), 64'(4));
            check("bclk_low_at_first_fall", 64'(bclk), 64'(0));
         end
         begin
            for (int i = 0; i < 4; i++)
               send(vecs[i].l, vecs[i].r, vecs[i].el, vecs[i].er, 1'b0);
         end
      join

      // Idle for three frames: zeros, one underrun pulse per frame start.
      wait_q_empty("drain_table");
      s0 = n_starts; u0 = n_under; r0 = ready_low;
      t = 0;
      while (n_starts < s0 + 3 && t < 4 * TMO) begin
         @(negedge clk); #1;
         t++;
      end
      if (n_starts < s0 + 3) timeout("idle_frames");
      check("idle_underrun_pulses", 64'(n_under - u0), 64'(3));
      check("idle_ready_low_cycles", 64'(ready_low - r0), 64'(0));

      // Valid held high with (n, ~n), n = 1..6.
      u0 = n_under;
      for (int n = 1; n <= 6; n++) begin
         logic [DW-1:0] nv;
         nv = DW'(n);
         send(nv, ~nv, nv, ~nv, n < 6);
      end
      wait_q_empty("drain_stream");
      check("stream_no_underrun", 64'(n_under - u0), 64'(0));

      // Reset in the right slot at p=10 while a pair is buffered.
      send(16'h5A5A, 16'hC3C3, 16'h5A5A, 16'hC3C3, 1'b0);
      t = 0;
      while (fall_idx != 42 && t < TMO) begin
         @(negedge clk); #1;
         t++;
      end
      if (fall_idx != 42) timeout("wait_right_p10");
      check("buffer_full_before_reset", 64'(sample_ready), 64'(0));
      check("right_slot_before_reset", 64'(lrclk), 64'(1));
      mon_en    = 1'b0;
      capturing = 1'b0;
      q.delete();
      reset = 1'b0;
      @(negedge clk); #1;
      check("midrun_reset_outputs", 64'({bclk, lrclk, sdata, sample_ready, underrun}), 64'(5'b01010));
      @(negedge clk); #1;
      s0 = n_starts; u0 = n_under; d0 = n_done;
      reset  = 1'b1;
      mon_en = 1'b1;
      wait_done(d0 + 1, "post_reset_frame");
      check("post_reset_frame_starts", 64'(n_starts - s0), 64'(1));
      check("post_reset_underrun_pulses", 64'(n_under - u0), 64'(1));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
